// File: rtl/ls_pkg.sv
// Shared load/store size codes and the load FSM state encoding.
// Imported by the load-size unit and the store-size merge block.
package ls_pkg;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ls_state_t;

endpackage

// File: rtl/ls_extract.sv
// Pure combinational lane extraction for loads, zero-extended.
// Always uses the low lanes, mirroring the store-side merge.
module ls_extract
  import ls_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (size)
      LS_BYTE: result = {24'h0, word[7:0]};
      LS_HALF: result = {16'h0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_size_unit.sv
// Multicycle load path: present address, wait MEM_LATENCY cycles,
// capture and extract word/halfword/byte for write-back.
module load_size_unit
  import ls_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  controleLS,
  input  logic [31:0] addr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] ls_out
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  ls_state_t   state;
  ls_state_t   state_nx;
  logic [3:0]  cnt;
  logic [1:0]  size_q;
  logic [31:0] extracted;

  ls_extract u_extract (
    .size   (size_q),
    .word   (mem_data_in),
    .result (extracted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Outputs decode only the state register: no input-to-output path.
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        mem_rd = 1'b1;
        if (cnt == 4'd0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      size_q   <= LS_WORD;
      cnt      <= '0;
      ls_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr <= addr;
            size_q   <= controleLS;
            cnt      <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) cnt    <= cnt - 4'd1;
          else             ls_out <= extracted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_size_unit.md
# load_size_unit

Load-side counterpart of the store-size merge path in the multicycle MIPS datapath. On a load request it drives the memory address, waits a fixed number of memory cycles, captures the returned word and extracts word, halfword or byte according to the load-size control, zero-extended to 32 bits. The control unit starts it with a one-cycle `start` pulse, and the result goes to the MDR/register-file write-back mux.

## Interface
- `MEM_LATENCY`, default 2: cycles between address presentation and valid `mem_data_in`. Legal range 1..15.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: load request. Sampled only in IDLE.
- `controleLS`  in  2: size select. 00 = word, 01 = byte, 10 = halfword, 11 = word.
- `addr`  in  32: load address. Sampled together with `start`.
- `mem_data_in`  in  32: memory read data.
- `mem_addr`  out  32: registered address to memory.
- `mem_rd`  out  1: memory read strobe. Memory write is never driven by this block.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `ls_out` is valid.
- `ls_out`  out  32: extracted, zero-extended load result. Held until the next capture.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On `start` = 1: latch `addr` into `mem_addr`, latch `controleLS` into internal `size_q`, load `cnt` with MEM_LATENCY−1, go to WAIT.
  - On `start` = 0: stay in IDLE.
- WAIT:
  - `mem_rd` = 1.
  - If `cnt` != 0: decrement `cnt`.
  - If `cnt` == 0: capture `mem_data_in` into `ls_out` using the extraction rule below, then go to DONE.
- DONE: `done` = 1, `mem_rd` = 0, go to IDLE unconditionally.
- Extraction uses `size_q`, never the live `controleLS`:
  - word / 11: `mem_data_in[31:0]`.
  - halfword: `{16'h0, mem_data_in[15:0]}`.
  - byte: `{24'h0, mem_data_in[7:0]}`.
- Extraction always takes the low lanes. Address bits [1:0] do not select a lane, matching the store-side merge, which writes the low lanes.
- `start` in WAIT or DONE is ignored, not queued. The control unit waits for `done` or `busy` = 0.
- `start` in the same cycle the FSM returns from DONE to IDLE is not seen. It is accepted in the following cycle if still high.
- Changes to `controleLS`, `addr` or `mem_data_in` outside their sample points have no effect.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, `mem_addr` = 0, `mem_rd` = 0, `busy` = 0, `done` = 0, `ls_out` = 0, `cnt` = 0.
- Let edge E be the rising edge that samples `start`.
- `mem_addr` is valid and `mem_rd` is high from E until the capture edge, which is E + MEM_LATENCY. `mem_rd` is therefore high for exactly MEM_LATENCY cycles.
- `ls_out` updates at E + MEM_LATENCY. `done` is high for the cycle after that edge.
- Request-to-result latency is MEM_LATENCY + 1 cycles including the DONE cycle. The minimum start-to-start interval is MEM_LATENCY + 2 cycles.
- `mem_rd`, `busy` and `done` are decoded from the state register only, with no path from inputs.
- Reset asserted mid-operation, in any state: return to IDLE with all outputs at their reset values. Any partial load is discarded. No `done` pulse is produced.

## Structure
- Shared package `ls_pkg`:
  - size-code constants `LS_WORD` = 2'b00, `LS_BYTE` = 2'b01, `LS_HALF` = 2'b10.
  - FSM state enum.
- The store-size block also uses `ls_pkg` for the same size codes.
- One combinational sub-module, `ls_extract`, with inputs (`size`, `word`) and output `result`. It is pure extraction logic so it can be reused and unit-tested standalone.
- The FSM, counter and output registers live in the top module.

## Test plan
- **Reset:** assert `reset` mid-WAIT -> all outputs 0 within the same cycle. After release, no `done` pulse; IDLE entered.
- **Word load, MEM_LATENCY = 2:** `start`, `addr` = 0x0000_0040, `controleLS` = 00, `mem_data_in` = 0xDEAD_BEEF -> `mem_addr` = 0x40 and `mem_rd` = 1 for 2 cycles; `done` in cycle 3; `ls_out` = 0xDEAD_BEEF.
- **Halfword and byte loads:** same memory word -> halfword gives `ls_out` = 0x0000_BEEF; byte gives `ls_out` = 0x0000_00EF. Vary `controleLS` after `start` -> result unchanged.
- **Code 11:** `controleLS` = 11, data 0x1234_5678 -> `ls_out` = 0x1234_5678.
- **Ignored start:** `start` held high continuously -> accepted once per MEM_LATENCY + 2 cycles. No extra `mem_rd` cycles; exactly one `done` per accepted request.
- **MEM_LATENCY = 1 build:** `mem_rd` high for 1 cycle, `done` in cycle 2, correct capture of data presented for one cycle only.
